// File: rtl/vga_prefetch_if.sv
// Memory read port between the pixel prefetch buffer and frame memory.
// One request at a time; the address is held until the acknowledge.
interface vga_prefetch_if;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 32;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/vga_prefetch.sv
// Pixel prefetch buffer: fetches 32-bit frame words ahead of scanout into a
// word FIFO and hands out one little-endian grey byte per pop.
module vga_prefetch #(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned FRAME_WORDS = 76800
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_rst,
  input  logic          pop,
  output logic [7:0]    rd,
  output logic          empty,
  output logic          underflow,
  vga_prefetch_if.master mem
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
  localparam int unsigned ADDR_W = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           fifo_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [1:0]            bsel_q, bsel_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  mem_req_q, mem_req_d;
  logic                  underflow_q, underflow_d;
  logic                  push;
  logic                  pop_word;
  logic [31:0]           head;

  // State register: FSM plus FIFO bookkeeping and the registered memory port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      bsel_q      <= '0;
      waddr_q     <= '0;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      bsel_q      <= bsel_d;
      waddr_q     <= waddr_d;
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      underflow_q <= underflow_d;
    end
  end

  // Word storage; push is already suppressed while flushing.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= mem.mem_rdata;
    end
  end

  // Next-state: fetch FSM, byte/word pop, occupancy, and frame flush.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    bsel_d      = bsel_q;
    waddr_d     = waddr_q;
    mem_addr_d  = mem_addr_q;
    mem_req_d   = 1'b0;
    underflow_d = underflow_q;
    push        = 1'b0;
    pop_word    = 1'b0;

    if (pop && !frame_rst) begin
      if (empty) begin
        underflow_d = 1'b1;
      end else if (bsel_q == 2'd3) begin
        bsel_d   = 2'd0;
        pop_word = 1'b1;
      end else begin
        bsel_d = bsel_q + 2'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (!frame_rst && (count_q < CNT_W'(DEPTH)) &&
            (waddr_q < ADDR_W'(FRAME_WORDS))) begin
          state_d    = REQ;
          mem_addr_d = waddr_q;
        end
      end
      REQ: begin
        // An issued request is never withdrawn; a flush only discards its data.
        if (frame_rst) begin
          state_d = mem.mem_ack ? IDLE : DRAIN;
        end else if (mem.mem_ack) begin
          push    = 1'b1;
          waddr_d = waddr_q + ADDR_W'(1);
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (mem.mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    mem_req_d = (state_d != IDLE);

    if (push) begin
      wptr_d = wptr_q + DEPTH_LOG2'(1);
    end
    if (pop_word) begin
      rptr_d = rptr_q + DEPTH_LOG2'(1);
    end
    case ({push, pop_word})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (frame_rst) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      bsel_d  = '0;
      waddr_d = '0;
    end
  end

  assign empty     = (count_q == '0);
  assign head      = fifo_q[rptr_q];
  assign rd        = empty ? 8'h00 : head[{bsel_q, 3'b000} +: 8];
  assign underflow = underflow_q;

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;

  // Only the single in-flight word can arrive, and only when a slot was free.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    push |-> ((count_q < CNT_W'(DEPTH)) || pop_word));

  a_addr_stable: assert property (@(posedge clk) disable iff (reset)
    (mem_req_q && !mem.mem_ack) |=> (mem_req_q && (mem_addr_q == $past(mem_addr_q))));

endmodule
